// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM/decode types, MMIO offsets and the address decoder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;
  typedef enum logic [1:0] {DEC_RAM, DEC_MMIO, DEC_ERR} dec_e;
  localparam logic [3:0] OFF_LED = 4'h0;
  localparam logic [3:0] OFF_CYC = 4'h4;
  localparam logic [3:0] OFF_SCR = 4'h8;
  function automatic dec_e decode(input logic [31:0] addr, input logic [31:0] base, input int aw);
    return addr[1:0] != 2'b00 ? DEC_ERR :
           addr[31:4] == base[31:4] ? (addr[3:0] == 4'hC ? DEC_ERR : DEC_MMIO) :
           (addr >> (aw + 2)) == 32'd0 ? DEC_RAM : DEC_ERR;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage request/response/stall bundle
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input req_ready, resp_valid, resp_rdata, resp_err, stall);
  modport slave (input req_valid, req_write, req_addr, req_wdata,
                 output req_ready, resp_valid, resp_rdata, resp_err, stall);
endinterface

// File: rtl/dmem_mmio_regs.sv
// dmem_mmio_regs: LED, scratch and free-running cycle-counter registers
module dmem_mmio_regs import dmem_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [3:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  led_o
);
  logic [7:0]  led_q, led_d;
  logic [31:0] scr_q, scr_d, cyc_q, cyc_d;
  always_comb begin
    led_d = we_i && off_i == OFF_LED ? wdata_i[7:0] : led_q;
    scr_d = we_i && off_i == OFF_SCR ? wdata_i : scr_q;
    cyc_d = cyc_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      scr_q <= '0;
      cyc_q <= '0;
    end else begin
      led_q <= led_d;
      scr_q <= scr_d;
      cyc_q <= cyc_d;
    end
  end
  assign rdata_o = off_i == OFF_LED ? {24'd0, led_q} :
                   off_i == OFF_CYC ? cyc_q :
                   off_i == OFF_SCR ? scr_q : '0;
  assign led_o = led_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage load/store responder driving sync RAM and a small MMIO window
module dmem_responder import dmem_pkg::*; #(
  parameter int          ADDR_W_RAM  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_responder_if.slave       bus,
  output logic [ADDR_W_RAM-1:0] ram_address_o,
  output logic [31:0]           ram_data_o,
  output logic                  ram_wren_o,
  input  logic [31:0]           ram_q_i,
  output logic [7:0]            led_out_o
);
  state_e                state_q, state_d;
  dec_e                  dec_q, dec_d;
  logic [ADDR_W_RAM+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d, mmio_rdata;
  logic                  write_q, write_d, err_q, err_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  mmio_we;
  assign mmio_we = state_q == ACCESS && write_q && dec_q == DEC_MMIO;
  dmem_mmio_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mmio_we),
    .off_i   (addr_q[3:0]),
    .wdata_i (wdata_q),
    .rdata_o (mmio_rdata),
    .led_o   (led_out_o)
  );
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr[ADDR_W_RAM+1:0];
        wdata_d = bus.req_wdata;
        write_d = bus.req_write;
        dec_d   = decode(bus.req_addr, MMIO_BASE, ADDR_W_RAM);
        state_d = ACCESS;
      end
      ACCESS: begin
        wcnt_d  = 4'(WAIT_STATES);
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          rdata_d = write_q ? '0 : dec_q == DEC_RAM ? ram_q_i : dec_q == DEC_MMIO ? mmio_rdata : '0;
          err_d   = dec_q == DEC_ERR;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dec_q   <= DEC_RAM;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      wcnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.stall      = (state_q == IDLE && bus.req_valid) || state_q == ACCESS || state_q == WAIT;
  assign ram_address_o  = addr_q[ADDR_W_RAM+1:2];
  assign ram_data_o     = wdata_q;
  // gated by rst so a store caught by reset in ACCESS never reaches the RAM
  assign ram_wren_o     = state_q == ACCESS && write_q && dec_q == DEC_RAM && !rst;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven scoreboard bench for WAIT_STATES=1 and WAIT_STATES=3 builds
module tb_dmem_responder;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
    int          wren;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        cd;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic sel = 1'b0, vld = 1'b0, wr = 1'b0;
  logic [31:0] ad = '0, wd = '0;
  dmem_responder_if b1 ();
  dmem_responder_if b3 ();
  assign b1.req_valid = vld & ~sel;
  assign b1.req_write = wr;
  assign b1.req_addr  = ad;
  assign b1.req_wdata = wd;
  assign b3.req_valid = vld & sel;
  assign b3.req_write = wr;
  assign b3.req_addr  = ad;
  assign b3.req_wdata = wd;
  logic [9:0]  ra1, ra3, wren_addr;
  logic [31:0] rd1, rd3, rq1, rq3;
  logic        we1, we3;
  logic [7:0]  led1, led3;
  dmem_responder #(.WAIT_STATES(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .ram_address_o(ra1), .ram_data_o(rd1),
    .ram_wren_o(we1), .ram_q_i(rq1), .led_out_o(led1));
  dmem_responder #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3), .ram_address_o(ra3), .ram_data_o(rd3),
    .ram_wren_o(we3), .ram_q_i(rq3), .led_out_o(led3));
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  int wren_cnt = 0, cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we1) begin
      mem1[ra1] <= rd1;
      wren_cnt  <= wren_cnt + 1;
      wren_addr <= ra1;
    end
    rq1 <= mem1[ra1];
    if (we3) mem3[ra3] <= rd3;
    rq3 <= mem3[ra3];
  end
  logic rv, rdy, stl, err;
  logic [31:0] rdata;
  assign rv    = sel ? b3.resp_valid : b1.resp_valid;
  assign rdy   = sel ? b3.req_ready  : b1.req_ready;
  assign stl   = sel ? b3.stall      : b1.stall;
  assign err   = sel ? b3.resp_err   : b1.resp_err;
  assign rdata = sel ? b3.resp_rdata : b1.resp_rdata;
  int checks = 0, fails = 0;
  exp_t sbq[$];
  vec_t tab[17];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] er,
                      input logic ee, input logic cd, input string nm, output logic [31:0] got, output int acc);
    int lat, st;
    bit done;
    exp_t e;
    @(negedge clk);
    vld = 1'b1; wr = w; ad = a; wd = d; acc = cyc;
    e.rdata = er; e.err = ee; e.cd = cd;
    sbq.push_back(e);
    #1;
    chk({nm, " ready"}, 32'(rdy), 32'd1);
    st = int'(stl); lat = 1; done = 1'b0; got = '0;
    @(negedge clk);
    vld = 1'b0; wr = 1'($urandom); ad = $urandom; wd = $urandom;
    while (!done && lat <= 20) begin
      #1;
      if (rv) begin
        if (sbq.size() == 0) begin
          checks++; fails++;
          $display("FAIL %s unexpected response got=%h", nm, rdata);
        end else begin
          e = sbq.pop_front();
          got = rdata;
          if (e.cd) chk({nm, " rdata"}, rdata, e.rdata);
          chk({nm, " err"}, 32'(err), 32'(e.err));
        end
        chk({nm, " latency"}, lat, sel ? 5 : 3);
        chk({nm, " stall cycles"}, st, sel ? 5 : 3);
        chk({nm, " stall in resp"}, 32'(stl), 32'd0);
        chk({nm, " ready in resp"}, 32'(rdy), 32'd0);
        done = 1'b1;
      end else begin
        st += int'(stl);
        @(negedge clk);
        lat++;
      end
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL %s timeout got=no_response want=resp_valid", nm);
      void'(sbq.pop_front());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] got, c1, c2;
    int acc, acc1, c0;
    bit seen;
    tab[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    tab[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    tab[2]  = '{1'b1, 32'h0000_0012, 32'h1111_1111, 32'h0,         1'b1, 0};
    tab[3]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    tab[4]  = '{1'b1, MB + 32'h0,    32'h0000_01A5, 32'h0,         1'b0, 0};
    tab[5]  = '{1'b0, MB + 32'h0,    32'h0,         32'h0000_00A5, 1'b0, 0};
    tab[6]  = '{1'b1, MB + 32'h4,    32'h0000_0005, 32'h0,         1'b0, 0};
    tab[7]  = '{1'b0, MB + 32'hC,    32'h0,         32'h0,         1'b1, 0};
    tab[8]  = '{1'b1, MB + 32'h8,    32'hCAFE_F00D, 32'h0,         1'b0, 0};
    tab[9]  = '{1'b0, MB + 32'h8,    32'h0,         32'hCAFE_F00D, 1'b0, 0};
    tab[10] = '{1'b0, 32'h0001_0000, 32'h0,         32'h0,         1'b1, 0};
    tab[11] = '{1'b1, 32'h0001_0000, 32'h7777_7777, 32'h0,         1'b1, 0};
    tab[12] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'h0,         1'b0, 1};
    tab[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h1234_5678, 1'b0, 0};
    tab[14] = '{1'b1, MB + 32'hC,    32'h5555_5555, 32'h0,         1'b1, 0};
    tab[15] = '{1'b0, MB + 32'h1,    32'h0,         32'h0,         1'b1, 0};
    tab[16] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0,         1'b0, 1};
    repeat (3) @(negedge clk);
    #1;
    chk("rst ready",  32'(b1.req_ready), 32'd1);
    chk("rst rvalid", 32'(b1.resp_valid), 32'd0);
    chk("rst rdata",  b1.resp_rdata, 32'd0);
    chk("rst err",    32'(b1.resp_err), 32'd0);
    chk("rst wren",   32'(we1), 32'd0);
    chk("rst led",    32'(led1), 32'd0);
    chk("rst ready3", 32'(b3.req_ready), 32'd1);
    chk("rst rvalid3", 32'(b3.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle stall", 32'(stl), 32'd0);
    for (int i = 0; i < 17; i++) begin
      c0 = wren_cnt;
      xact(tab[i].w, tab[i].a, tab[i].d, tab[i].er, tab[i].ee, 1'b1, $sformatf("vec%0d", i), got, acc);
      chk($sformatf("vec%0d wren count", i), 32'(wren_cnt - c0), 32'(tab[i].wren));
      if (tab[i].wren != 0) chk($sformatf("vec%0d wren addr", i), 32'(wren_addr), 32'(tab[i].a[11:2]));
    end
    chk("led after store", 32'(led1), 32'h0000_00A5);
    xact(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, "cyc a", c1, acc);
    repeat (3) @(negedge clk);
    xact(1'b0, MB + 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, "cyc b", c2, acc);
    chk("cyc delta", c2 - c1, 32'd7);
    c0 = wren_cnt;
    @(negedge clk);
    vld = 1'b1; wr = 1'b1; ad = 32'h0000_0020; wd = 32'hFFFF_FFFF;
    @(negedge clk);
    vld = 1'b0; rst = 1'b1;
    #1;
    chk("abort wren", 32'(we1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort ready", 32'(rdy), 32'd1);
    chk("abort rvalid", 32'(rv), 32'd0);
    chk("abort led", 32'(led1), 32'd0);
    chk("abort stall", 32'(stl), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (rv) seen = 1'b1;
    end
    chk("abort no resp", 32'(seen), 32'd0);
    chk("abort wren count", 32'(wren_cnt - c0), 32'd0);
    xact(1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1, "old 0x20", got, acc);
    xact(1'b0, MB + 32'h8, 32'h0, 32'h0, 1'b0, 1'b1, "scratch reset", got, acc);
    sel = 1'b1;
    xact(1'b1, 32'h0000_0040, 32'h0000_55AA, 32'h0, 1'b0, 1'b1, "ws3 store", got, acc1);
    xact(1'b0, 32'h0000_0040, 32'h0, 32'h0000_55AA, 1'b0, 1'b1, "ws3 load", got, acc);
    chk("ws3 b2b spacing", 32'(acc - acc1), 32'd6);
    acc1 = acc;
    xact(1'b0, 32'h0000_0042, 32'h0, 32'h0, 1'b1, 1'b1, "ws3 misaligned", got, acc);
    chk("ws3 b2b spacing 2", 32'(acc - acc1), 32'd6);
    chk("scoreboard empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
